fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction-fetch stage; sits directly upstream of the instruction memory.
// - Owns the program counter and drives it to the memory's combinational read port.
// - Registers the returned word into an instruction register with a valid flag for the decoder.
// - Handles start, stall, jump (with one-bubble flush) and end-of-program.
// PARAMETERS
// - PC_WIDTH           8       pc width; from shared parameters file; memory depth 2**PC_WIDTH
// - INSTRUCTION_WIDTH  (pkg)   instruction word width; from shared parameters file
// - RESET_PC           'h00    pc value loaded on reset
// - PROG_END           'h32    address of last program word; used only under FETCH_HALT_EN
// PORTS
// - clk          in   1                  single clock; all state updates on posedge
// - rst          in   1                  synchronous, active-high reset
// - start        in   1                  1-cycle pulse: leave IDLE and begin fetching
// - stall        in   1                  downstream not ready: hold pc, IR and valid
// - jump         in   1                  redirect fetch to jump_addr
// - jump_addr    in   PC_WIDTH           jump target
// - pc           out  PC_WIDTH           address to instruction memory (registered)
// - instr_in     in   INSTRUCTION_WIDTH  memory data for current pc (same cycle, combinational)
// - instr_out    out  INSTRUCTION_WIDTH  instruction register
// - instr_pc     out  PC_WIDTH           address that instr_out was fetched from
// - instr_valid  out  1                  instr_out holds a live instruction
// - halted       out  1                  fetch stopped at PROG_END (tied 0 without FETCH_HALT_EN)
// BEHAVIOUR
// - Reset (synchronous, any cycle, including mid-jump or mid-stall):
//   - state=IDLE, pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0.
// - FSM states:
//   - IDLE: pc held, instr_valid=0. start=1 -> RUN.
//   - RUN: normal fetch.
//   - HALT: only with FETCH_HALT_EN. Exits only via rst.
// - RUN, per-cycle priority: jump > stall > advance.
// - Advance (no jump, no stall):
//   - IR<=instr_in, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
//   - Latency is 1 cycle: pc=A in cycle N gives instr_out=mem[A] in cycle N+1.
// - Stall (no jump): pc, IR, instr_pc and instr_valid all hold.
// - Jump (stall ignored):
//   - pc<=jump_addr, instr_valid<=0. This is one bubble; the sequential word is discarded.
//   - The next cycle fetches jump_addr.
// - jump or stall while in IDLE: ignored. start while in RUN: ignored.
// - pc arithmetic is unsigned, modulo 2**PC_WIDTH: pc='hFF advances to 'h00 with no flag.
// - jump_addr is taken verbatim; no alignment or range check.
// CONFIGURATION
// - Macro FETCH_HALT_EN.
// - Defined:
//   - On an advance with pc==PROG_END: the word is captured (valid=1), pc holds, next state=HALT.
//   - In HALT: halted=1; instr_valid drops to 0 the cycle after the last word is consumed (stall=0).
//   - A jump in the same cycle as the PROG_END advance wins; no halt occurs.
// - Undefined: no HALT state; halted tied 0; pc runs through PROG_END and wraps modulo 2**PC_WIDTH.
// STRUCTURE
// - Shared package: fetch_state_t enum {IDLE, RUN, HALT}; PC_WIDTH, INSTRUCTION_WIDTH, RESET_PC.
// - Decoder and memory read these constants from the same package.
// - One sub-module: fetch_ir, the instruction/instr_pc/valid register with load, hold and flush inputs.
// - The FSM and pc logic stay in fetch_unit.
// TESTING
// - Bench pairs fetch_unit with a memory model preloaded mem[i]=i+'h100.
// - Test 1: rst, then start at cycle 2.
//   - Expect: cycle 3 instr_out='h100/instr_pc=0/valid=1; cycle 4 'h101/1.
// - Test 2: stall held for 3 cycles at pc=5.
//   - Expect: pc stays 5; instr_out stays 'h104 and valid stays 1.
//   - Expect: the cycle after release, instr_out='h105.
// - Test 3: jump=1, jump_addr='h20 with stall=1 in the same cycle.
//   - Expect: next cycle pc='h20 and valid=0; cycle after, instr_out='h120, instr_pc='h20.
// - Test 4: jump to 'hFE and run 3 cycles.
//   - Expect: pc sequence FE, FF, 00.
//   - Expect: instr_pc 'hFF followed by 'h00, no glitch on valid.
// - Test 5: FETCH_HALT_EN defined, PROG_END='h32.
//   - Expect: last word 'h132 valid; then halted=1, pc='h32, valid=0.
//   - Expect: start and jump ignored while halted.
// - Test 6: rst asserted mid-run at pc='h10.
//   - Expect: next cycle pc=RESET_PC, valid=0, state IDLE.
//   - Expect: fetch resumes only on start.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module : fetch_unit_pkg
// Brief  : Shared fetch-stage constants and the fetch FSM state type. The
//          decoder and instruction memory import the same widths.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  localparam int PC_WIDTH          = 8;
  localparam int INSTRUCTION_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module : fetch_unit_if
// Brief  : Instruction-memory read bus between the fetch stage and memory.
// Ports  : pc       - fetch address, driven by the fetch stage
//          instr_in - memory word at pc, returned combinationally
// Modports: master (fetch side), slave (memory side)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [PC_WIDTH-1:0]          pc;
  logic [INSTRUCTION_WIDTH-1:0] instr_in;

  modport master (output pc, input instr_in);
  modport slave  (input pc, output instr_in);

endinterface

`default_nettype wire

// File: rtl/fetch_unit_ir.sv
//------------------------------------------------------------------------------
// Module : fetch_ir
// Brief  : Instruction register with its source address and valid flag.
// Ports  : clk, rst          - clock, synchronous active-high reset
//          load              - capture instr_d/pc_d and mark valid
//          hold              - keep everything as is
//          flush             - drop valid (jump bubble)
//          instr_d, pc_d     - word and address to capture
//          instr_q, pc_q     - registered word and address
//          valid_q           - instr_q holds a live instruction
// Priority: flush > hold > load; with none asserted valid falls to 0.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ir
  import fetch_unit_pkg::*;
(
  input  wire                          clk,
  input  wire                          rst,
  input  wire                          load,
  input  wire                          hold,
  input  wire                          flush,
  input  wire  [INSTRUCTION_WIDTH-1:0] instr_d,
  input  wire  [PC_WIDTH-1:0]          pc_d,
  output logic [INSTRUCTION_WIDTH-1:0] instr_q,
  output logic [PC_WIDTH-1:0]          pc_q,
  output logic                         valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      // Word and address are left stale; only valid matters downstream.
      valid_q <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
        valid_q <= 1'b1;
      end else begin
        // Idle or halted with the consumer ready: the last word drains.
        valid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module : fetch_unit
// Brief  : Instruction-fetch stage. Owns the program counter, drives it to
//          the instruction memory and registers the returned word for the
//          decoder. Handles start, stall, jump (one-bubble flush) and, when
//          FETCH_HALT_EN is defined, halting at PROG_END.
// Ports  : clk, rst      - clock, synchronous active-high reset
//          start         - pulse: leave IDLE and begin fetching
//          stall         - downstream not ready: hold pc and IR
//          jump          - redirect fetch to jump_addr (beats stall)
//          jump_addr     - jump target, taken verbatim
//          mem           - memory bus (pc out, instr_in back)
//          instr_out     - instruction register
//          instr_pc      - address instr_out was fetched from
//          instr_valid   - instr_out is live
//          halted        - fetch stopped at PROG_END (0 without FETCH_HALT_EN)
// Config : FETCH_HALT_EN - enables the HALT state at PROG_END
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PROG_END = 8'h32
)(
  input  wire                          clk,
  input  wire                          rst,
  input  wire                          start,
  input  wire                          stall,
  input  wire                          jump,
  input  wire  [PC_WIDTH-1:0]          jump_addr,
  fetch_unit_if.master                 mem,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  output logic                         halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                end_hit;
  logic                ir_load;
  logic                ir_hold;
  logic                ir_flush;

  assign mem.pc  = pc_q;
  // Constant 0 without the halt feature, so HALT is unreachable there.
  assign end_hit = HALT_EN && (pc_q == PROG_END);

  // IR control: RUN fetches unless jumping or stalled; HALT only lets the
  // final word sit until it is consumed.
  always_comb begin
    ir_load  = 1'b0;
    ir_hold  = 1'b0;
    ir_flush = 1'b0;
    case (state)
      RUN: begin
        if (jump)       ir_flush = 1'b1;
        else if (stall) ir_hold  = 1'b1;
        else            ir_load  = 1'b1;
      end
      HALT: ir_hold = stall;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (jump) begin
            pc_q <= jump_addr;
          end else if (!stall) begin
            if (end_hit) begin
              // Last word is captured this cycle; pc stays on PROG_END.
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        HALT: halted <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_ir u_fetch_ir (
    .clk     (clk),
    .rst     (rst),
    .load    (ir_load),
    .hold    (ir_hold),
    .flush   (ir_flush),
    .instr_d (mem.instr_in),
    .pc_d    (pc_q),
    .instr_q (instr_out),
    .pc_q    (instr_pc),
    .valid_q (instr_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit with a combinational
//          memory model holding mem[i] = i + 'h100.
// Config : FETCH_HALT_EN selects the halt-at-PROG_END checks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start;
  logic                         stall;
  logic                         jump;
  logic [PC_WIDTH-1:0]          jump_addr;
  logic [INSTRUCTION_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]          instr_pc;
  logic                         instr_valid;
  logic                         halted;

  int tests = 0;
  int fails = 0;

  fetch_unit_if bus ();

  // Memory model: word at address i is i + 'h100.
  assign bus.instr_in = INSTRUCTION_WIDTH'(bus.pc) + 16'h0100;

  fetch_unit #(.PROG_END(8'h32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .mem         (bus),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0;
    step();
    step();
    check("rst_pc",     bus.pc,      8'h00);
    check("rst_valid",  instr_valid, 1'b0);
    check("rst_instr",  instr_out,   16'h0000);
    check("rst_ipc",    instr_pc,    8'h00);
    check("rst_halted", halted,      1'b0);
    rst = 1'b0;

    // Test 1: start, then sequential fetch.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_pc_start",    bus.pc,      8'h00);
    check("t1_valid_start", instr_valid, 1'b0);
    step();
    check("t1_instr0", instr_out,   16'h0100);
    check("t1_ipc0",   instr_pc,    8'h00);
    check("t1_valid0", instr_valid, 1'b1);
    check("t1_pc1",    bus.pc,      8'h01);
    step();
    check("t1_instr1", instr_out, 16'h0101);
    check("t1_ipc1",   instr_pc,  8'h01);

    // Test 2: stall for three cycles at pc=5.
    repeat (3) step();
    check("t2_pc5",    bus.pc,    8'h05);
    check("t2_instr4", instr_out, 16'h0104);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_pc",    bus.pc,      8'h05);
      check("t2_stall_instr", instr_out,   16'h0104);
      check("t2_stall_valid", instr_valid, 1'b1);
    end
    stall = 1'b0;
    step();
    check("t2_release_instr", instr_out, 16'h0105);
    check("t2_release_pc",    bus.pc,    8'h06);

    // Test 3: jump with stall in the same cycle; jump wins.
    jump = 1'b1; jump_addr = 8'h20; stall = 1'b1;
    step();
    jump = 1'b0; stall = 1'b0;
    check("t3_pc",     bus.pc,      8'h20);
    check("t3_bubble", instr_valid, 1'b0);
    step();
    check("t3_instr", instr_out,   16'h0120);
    check("t3_ipc",   instr_pc,    8'h20);
    check("t3_valid", instr_valid, 1'b1);

    // Test 4: wrap from 'hFF to 'h00.
    jump = 1'b1; jump_addr = 8'hFE;
    step();
    jump = 1'b0;
    check("t4_pc_fe", bus.pc, 8'hFE);
    step();
    check("t4_pc_ff",    bus.pc,      8'hFF);
    check("t4_instr_fe", instr_out,   16'h01FE);
    check("t4_valid_fe", instr_valid, 1'b1);
    step();
    check("t4_pc_00",    bus.pc,      8'h00);
    check("t4_ipc_ff",   instr_pc,    8'hFF);
    check("t4_valid_ff", instr_valid, 1'b1);
    step();
    check("t4_pc_01",    bus.pc,      8'h01);
    check("t4_ipc_00",   instr_pc,    8'h00);
    check("t4_instr_00", instr_out,   16'h0100);
    check("t4_valid_00", instr_valid, 1'b1);

`ifdef FETCH_HALT_EN
    // Test 5: halt at PROG_END='h32.
    jump = 1'b1; jump_addr = 8'h30;
    step();
    jump = 1'b0;
    step();
    step();
    check("t5_pc_end", bus.pc, 8'h32);
    step();
    check("t5_last_instr", instr_out,   16'h0132);
    check("t5_last_valid", instr_valid, 1'b1);
    check("t5_halted",     halted,      1'b1);
    check("t5_pc_hold",    bus.pc,      8'h32);
    step();
    check("t5_drain_valid", instr_valid, 1'b0);
    check("t5_halted2",     halted,      1'b1);
    start = 1'b1; jump = 1'b1; jump_addr = 8'h40;
    step();
    start = 1'b0; jump = 1'b0;
    check("t5_ign_pc",     bus.pc,      8'h32);
    check("t5_ign_halted", halted,      1'b1);
    check("t5_ign_valid",  instr_valid, 1'b0);
    step();
    check("t5_ign_pc2", bus.pc, 8'h32);
`else
    // Test 5 (halt disabled): pc runs straight through PROG_END.
    jump = 1'b1; jump_addr = 8'h31;
    step();
    jump = 1'b0;
    step();
    check("t5_pc_end", bus.pc, 8'h32);
    step();
    check("t5_pc_past", bus.pc,      8'h33);
    check("t5_instr",   instr_out,   16'h0132);
    check("t5_valid",   instr_valid, 1'b1);
    check("t5_nohalt",  halted,      1'b0);
`endif

    // Test 6: reset mid-run at pc='h10, then resume only on start.
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    jump = 1'b1; jump_addr = 8'h0F;
    step();
    jump = 1'b0;
    step();
    check("t6_pc10",   bus.pc,    8'h10);
    check("t6_instr",  instr_out, 16'h010F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_pc",     bus.pc,      8'h00);
    check("t6_rst_valid",  instr_valid, 1'b0);
    check("t6_rst_halted", halted,      1'b0);
    check("t6_rst_ipc",    instr_pc,    8'h00);
    jump = 1'b1; jump_addr = 8'h55; stall = 1'b1;
    step();
    jump = 1'b0; stall = 1'b0;
    step();
    check("t6_idle_pc",    bus.pc,      8'h00);
    check("t6_idle_valid", instr_valid, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_start_pc", bus.pc, 8'h00);
    step();
    check("t6_resume_instr", instr_out,   16'h0100);
    check("t6_resume_valid", instr_valid, 1'b1);
    check("t6_resume_pc",    bus.pc,      8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
